uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 148 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter through a trans_en / tx_busy handshake.
// One byte is in flight at a time; it is popped once the transmitter reports busy.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              baud_clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              tx_enable,
  input  logic              ovf_clr,
  input  logic              tx_busy,
  output logic              trans_en,
  output logic [7:0]        data_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [15:0]       sent_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state_reg, state_next;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]     level_reg, level_next;
  logic                trans_en_reg, trans_en_next;
  logic [7:0]          data_out_reg;
  logic                overflow_reg, overflow_next;
  logic [15:0]         sent_count_reg;
  logic                full_w, empty_w;
  logic                push, drop, pop, load_byte;

  assign full_w  = (level_reg == DEPTH_L);
  assign empty_w = (level_reg == '0);
  // A write into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign push    = wr_en && !full_w;
  assign drop    = wr_en && full_w;

  always_comb begin
    state_next    = state_reg;
    trans_en_next = 1'b0;
    load_byte     = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_enable && !empty_w) begin
          state_next    = REQ;
          trans_en_next = 1'b1;
          load_byte     = 1'b1;
        end
      end
      REQ: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
          pop        = 1'b1;
        end else begin
          trans_en_next = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (tx_enable && !empty_w) begin
            state_next    = REQ;
            trans_en_next = 1'b1;
            load_byte     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        trans_en_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + (ADDR_W+1)'(1);
      2'b01:   level_next = level_reg - (ADDR_W+1)'(1);
      default: level_next = level_reg;
    endcase
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge baud_clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge baud_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      trans_en_reg   <= 1'b0;
      data_out_reg   <= 8'h00;
      overflow_reg   <= 1'b0;
      sent_count_reg <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      level_reg    <= level_next;
      trans_en_reg <= trans_en_next;
      overflow_reg <= overflow_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + ADDR_W'(1);
        sent_count_reg <= sent_count_reg + 16'h0001;
      end
      if (load_byte) begin
        data_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign trans_en   = trans_en_reg;
  assign data_out   = data_out_reg;
  assign full       = full_w;
  assign empty      = empty_w;
  assign level      = level_reg;
  assign overflow   = overflow_reg;
  assign sent_count = sent_count_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a 10-bit-frame transmitter model, a byte scoreboard
// filled on accepted writes and drained by the serial-line monitor.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              baud_clock = 1'b0;
  logic              reset_n    = 1'b0;
  logic              wr_en      = 1'b0;
  logic [7:0]        wr_data    = 8'h00;
  logic              tx_enable  = 1'b0;
  logic              ovf_clr    = 1'b0;
  logic              tx_busy;
  logic              trans_en;
  logic [7:0]        data_out;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic [15:0]       sent_count;

  always #5 baud_clock = ~baud_clock;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .baud_clock (baud_clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .tx_enable  (tx_enable),
    .ovf_clr    (ovf_clr),
    .tx_busy    (tx_busy),
    .trans_en   (trans_en),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .sent_count (sent_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Transmitter model: start bit, 8 data bits LSB first, stop bit, one guard cycle.
  logic       tx_line;
  logic [9:0] tx_frame;
  int         tx_cnt;
  always @(posedge baud_clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy  <= 1'b0;
      tx_line  <= 1'b1;
      tx_cnt   <= 0;
      tx_frame <= '1;
    end else if (!tx_busy) begin
      if (trans_en) begin
        tx_frame <= {1'b1, data_out, 1'b0};
        tx_line  <= 1'b0;
        tx_busy  <= 1'b1;
        tx_cnt   <= 1;
      end
    end else if (tx_cnt < 10) begin
      tx_line <= tx_frame[tx_cnt];
      tx_cnt  <= tx_cnt + 1;
    end else if (tx_cnt == 10) begin
      tx_line <= 1'b1;
      tx_cnt  <= 11;
    end else begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end
  end

  // Scoreboard fill: bytes the FIFO must accept, tracked from the handshake.
  logic [7:0] exp_q[$];
  int         model_level;
  bit         m_acc, m_pop;
  always @(posedge baud_clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      model_level = 0;
    end else begin
      m_acc = wr_en && (model_level < DEPTH);
      m_pop = trans_en && tx_busy;
      if (m_acc) exp_q.push_back(wr_data);
      model_level = model_level + int'(m_acc) - int'(m_pop);
    end
  end

  int cycle = 0;
  always @(posedge baud_clock) cycle++;

  // Serial-line monitor: rebuild each frame, compare against the scoreboard.
  logic [9:0] rx_bits    = '0;
  logic [9:0] last_frame = '0;
  int         frames_seen = 0;
  int         rise_cyc[$];
  logic       te_prev = 1'b0;
  logic [7:0] exp_byte;
  always @(negedge baud_clock) begin
    if (trans_en && !te_prev) rise_cyc.push_back(cycle);
    te_prev = trans_en;
    if (tx_busy && tx_cnt >= 1 && tx_cnt <= 10) begin
      rx_bits[tx_cnt-1] = tx_line;
      if (tx_cnt == 10) begin
        last_frame = rx_bits;
        frames_seen++;
        $display("frame %0d: byte 0x%02h at cycle %0d", frames_seen, rx_bits[8:1], cycle);
        check_val("framing", 32'({rx_bits[9], rx_bits[0]}), 32'h2);
        check_val("sb_pending", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          exp_byte = exp_q.pop_front();
          check_val("sb_byte", 32'(rx_bits[8:1]), 32'(exp_byte));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge baud_clock);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(frames_seen), 32'(target));
  endtask

  task automatic wait_level(input logic [ADDR_W:0] from, output logic [ADDR_W:0] to);
    int n = 0;
    while (level == from && n < 40) begin
      tick();
      n++;
    end
    to = level;
  endtask

  task automatic wait_pop_edge(input string tag);
    int n = 0;
    while (!(trans_en && tx_busy) && n < 40) begin
      tick();
      n++;
    end
    check_val(tag, 32'(trans_en && tx_busy), 32'h1);
  endtask

  task automatic check_gaps(input string tag, input int count);
    check_val({tag, "_rises"}, 32'(rise_cyc.size()), 32'(count));
    for (int i = 1; i < rise_cyc.size(); i++)
      check_val({tag, "_gap"}, 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd13);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W:0] lvl;

  initial begin
    // Reset values
    tick(2);
    check_val("rst_trans_en", 32'(trans_en), 32'h0);
    check_val("rst_data_out", 32'(data_out), 32'h00);
    check_val("rst_level", 32'(level), 32'h0);
    check_val("rst_empty", 32'(empty), 32'h1);
    check_val("rst_full", 32'(full), 32'h0);
    check_val("rst_overflow", 32'(overflow), 32'h0);
    check_val("rst_sent", 32'(sent_count), 32'h0);
    reset_n = 1'b1;
    tick();

    // Single byte with latency and serial pattern
    tx_enable = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check_val("single_level_k", 32'(level), 32'h1);
    check_val("single_te_k", 32'(trans_en), 32'h0);
    tick();
    check_val("single_te_k1", 32'(trans_en), 32'h1);
    check_val("single_data", 32'(data_out), 32'hA5);
    wait_frames("single_frames", 1, 40);
    tick(4);
    check_val("single_line", 32'(last_frame), 32'h34A);
    check_val("single_sent", 32'(sent_count), 32'h1);
    check_val("single_empty", 32'(empty), 32'h1);
    check_val("single_te_idle", 32'(trans_en), 32'h0);

    // Burst of three
    rise_cyc.delete();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    check_val("burst_level", 32'(level), 32'h3);
    wait_level(3'(3), lvl);  check_val("burst_level", 32'(lvl), 32'h2);
    wait_level(lvl, lvl);    check_val("burst_level", 32'(lvl), 32'h1);
    wait_level(lvl, lvl);    check_val("burst_level", 32'(lvl), 32'h0);
    wait_frames("burst_frames", 4, 60);
    tick(4);
    check_gaps("burst", 3);

    // Overflow with transmitter paused
    tx_enable = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) write_byte(8'h10 + 8'(i));
    check_val("ovf_full", 32'(full), 32'h1);
    check_val("ovf_level", 32'(level), 32'(DEPTH));
    check_val("ovf_flag", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("ovf_cleared", 32'(overflow), 32'h0);

    // Write coinciding with the pop edge while full
    rise_cyc.delete();
    tx_enable = 1'b1;
    wait_pop_edge("simul_reach");
    check_val("simul_pre_level", 32'(level), 32'(DEPTH));
    write_byte(8'hEE);
    check_val("simul_ovf", 32'(overflow), 32'h1);
    check_val("simul_level", 32'(level), 32'd15);
    check_val("simul_full", 32'(full), 32'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    wait_frames("ovf_frames", 20, DEPTH * 13 + 60);
    tick(30);
    check_val("ovf_no_extra", 32'(frames_seen), 32'd20);
    check_val("ovf_sent", 32'(sent_count), 32'd20);
    check_val("ovf_empty", 32'(empty), 32'h1);
    check_gaps("drain", DEPTH);

    // Pause during WAIT_DONE
    write_byte(8'h5A);
    write_byte(8'hC3);
    begin
      int n = 0;
      while (!(tx_busy && !trans_en) && n < 30) begin tick(); n++; end
      check_val("pause_reach", 32'(tx_busy && !trans_en), 32'h1);
    end
    tx_enable = 1'b0;
    wait_frames("pause_first", 21, 40);
    tick(10);
    check_val("pause_te", 32'(trans_en), 32'h0);
    check_val("pause_level", 32'(level), 32'h1);
    check_val("pause_sent", 32'(sent_count), 32'd21);
    tx_enable = 1'b1;
    tick();
    check_val("resume_te", 32'(trans_en), 32'h1);
    check_val("resume_data", 32'(data_out), 32'hC3);
    wait_frames("resume_frames", 22, 40);
    tick(4);
    check_val("resume_sent", 32'(sent_count), 32'd22);

    // Reset mid-byte with five queued
    tx_enable = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'h71 + 8'(i));
    tx_enable = 1'b1;
    tick();
    check_val("rst_mid_te_pre", 32'(trans_en), 32'h1);
    check_val("rst_mid_lvl_pre", 32'(level), 32'h5);
    reset_n = 1'b0;
    #1;
    check_val("rst_mid_te", 32'(trans_en), 32'h0);
    check_val("rst_mid_level", 32'(level), 32'h0);
    check_val("rst_mid_empty", 32'(empty), 32'h1);
    tick();
    reset_n = 1'b1;
    tick(40);
    check_val("rst_after_frames", 32'(frames_seen), 32'd22);
    check_val("rst_after_te", 32'(trans_en), 32'h0);
    check_val("rst_after_sent", 32'(sent_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
